// File: rtl/hamming_pkg.sv
// hamming_pkg: shared Hamming(7,4) widths, FSM state encoding and encoder function.
package hamming_pkg;
  localparam int CW_W = 7;
  localparam int DATA_W = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP = 2'd2;
  typedef enum logic [1:0] {S_IDLE = ST_IDLE, S_SHIFT = ST_SHIFT, S_GAP = ST_GAP} state_e;
  // Codeword {a,b,c,d,e,f,g}; parity chosen so the receive corrector sees a zero syndrome.
  function automatic logic [CW_W-1:0] hamming74_encode(input logic [DATA_W-1:0] d);
    return {d, d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d[2] ^ d[1] ^ d[0]};
  endfunction
endpackage

// File: rtl/hamming74_enc.sv
// hamming74_enc: combinational Hamming(7,4) encoder, nibble in, codeword out.
module hamming74_enc
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [CW_W-1:0]   cw_o
);
  assign cw_o = hamming74_encode(data_i);
endmodule

// File: rtl/hamming_tx_serializer.sv
// hamming_tx_serializer: accepts nibbles, encodes Hamming(7,4), shifts codeword out MSB-first.
module hamming_tx_serializer
  import hamming_pkg::*;
#(
  parameter int DIV = 1,
  parameter int GAP = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_bit,
  output logic              tx_en,
  output logic              tx_sof,
  output logic [CW_W-1:0]   cw_out,
  output logic              busy
);
  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
  state_e            state_q;
  logic [CW_W-1:0]   shreg_q, cw_q, cw_d;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        div_cnt_q, gap_cnt_q;
  hamming74_enc u_enc (.data_i(in_data), .cw_o(cw_d));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      cw_q      <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          cw_q      <= cw_d;
          shreg_q   <= cw_d;
          bit_cnt_q <= '0;
          div_cnt_q <= '0;
          state_q   <= S_SHIFT;
        end
        S_SHIFT: if (div_cnt_q == DIV_LAST) begin
          div_cnt_q <= '0;
          shreg_q   <= shreg_q << 1;
          if (bit_cnt_q == 3'd6) begin
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            state_q   <= GAP > 0 ? S_GAP : S_IDLE;
          end else begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end else begin
          div_cnt_q <= div_cnt_q + 8'd1;
        end
        S_GAP: if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_q <= '0;
          state_q   <= S_IDLE;
        end else begin
          gap_cnt_q <= gap_cnt_q + 8'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign tx_en    = state_q == S_SHIFT;
  assign tx_bit   = tx_en & shreg_q[CW_W-1];
  assign tx_sof   = tx_en && bit_cnt_q == 3'd0 && div_cnt_q == 8'd0;
  assign in_ready = state_q == S_IDLE;
  assign busy     = !in_ready;
  assign cw_out   = cw_q;
endmodule

// File: tb/tb_hamming_tx_serializer.sv
// tb_hamming_tx_serializer: directed scoreboard bench for two parameterisations of the serializer.
module tb_hamming_tx_serializer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic a_valid = 1'b0, a_ready, a_bit, a_en, a_sof, a_busy;
  logic b_valid = 1'b0, b_ready, b_bit, b_en, b_sof, b_busy;
  logic [3:0] a_data = '0, b_data = '0;
  logic [6:0] a_cw, b_cw, a_rx, b_rx, a_last;
  logic [6:0] qa[$], qb[$];
  int a_sofs[$], b_sofs[$];
  int cyc = 0, checks = 0, errors = 0;
  int a_n = 0, b_n = 0, a_frames = 0, b_frames = 0, idle_err = 0, hold_err = 0;

  hamming_tx_serializer #(.DIV(1), .GAP(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
    .tx_bit(a_bit), .tx_en(a_en), .tx_sof(a_sof), .cw_out(a_cw), .busy(a_busy));
  hamming_tx_serializer #(.DIV(3), .GAP(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .tx_bit(b_bit), .tx_en(b_en), .tx_sof(b_sof), .cw_out(b_cw), .busy(b_busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    return {d, d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d[2] ^ d[1] ^ d[0]};
  endfunction

  function automatic logic [2:0] syn(input logic [6:0] r);
    return {r[6] ^ r[5] ^ r[3] ^ r[2], r[6] ^ r[4] ^ r[3] ^ r[1], r[5] ^ r[4] ^ r[3] ^ r[0]};
  endfunction

  // Independent corrector model: flip the single position whose syndrome column matches.
  function automatic logic [3:0] correct(input logic [6:0] r);
    logic [6:0] c = r;
    for (int k = 0; k < 7; k++) if (syn(7'(1 << k)) == syn(r)) c[k] = ~c[k];
    return c[6:3];
  endfunction

  always @(negedge clk) begin
    if (!rst_n) a_n = 0;
    else if (!a_en) idle_err += int'(a_bit);
    else begin
      if (a_sof) begin a_n = 0; a_sofs.push_back(cyc); end
      a_rx[3'(6 - a_n)] = a_bit;
      a_n++;
      if (a_n == 7) begin
        a_n = 0;
        a_last = a_rx;
        a_frames++;
        chk("a_frame", 32'(a_rx), qa.size() > 0 ? 32'(qa.pop_front()) : 32'hdead);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) b_n = 0;
    else if (!b_en) idle_err += int'(b_bit);
    else begin
      if (b_sof) begin b_n = 0; b_sofs.push_back(cyc); end
      if (b_n % 3 == 0) b_rx[3'(6 - b_n / 3)] = b_bit;
      else if (b_rx[3'(6 - b_n / 3)] !== b_bit) hold_err++;
      b_n++;
      if (b_n == 21) begin
        b_n = 0;
        b_frames++;
        chk("b_frame", 32'(b_rx), qb.size() > 0 ? 32'(qb.pop_front()) : 32'hdead);
      end
    end
  end

  task automatic wait_rdy_a();
    int t = 0;
    while (!a_ready && t < 100) begin @(negedge clk); t++; end
    chk("a_ready_wait", 32'(a_ready), 32'd1);
  endtask

  task automatic wait_rdy_b();
    int t = 0;
    while (!b_ready && t < 200) begin @(negedge clk); t++; end
    chk("b_ready_wait", 32'(b_ready), 32'd1);
  endtask

  task automatic send_a(input logic [3:0] n);
    wait_rdy_a();
    a_valid = 1'b1;
    a_data = n;
    qa.push_back(enc(n));
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic wait_frames_a(input int target);
    int t = 0;
    while (a_frames < target && t < 100) begin @(negedge clk); t++; end
    chk("a_frame_wait", 32'(a_frames >= target), 32'd1);
  endtask

  initial begin
    logic [3:0] v[3];
    logic [6:0] x[3];
    int lo, sc, ec, gl, f0;
    v = '{4'h0, 4'hF, 4'b1000};
    x = '{7'h00, 7'h7F, 7'h46};
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_en", 32'(a_en), 32'd0);
    chk("rst_bit", 32'(a_bit), 32'd0);
    chk("rst_sof", 32'(a_sof), 32'd0);
    chk("rst_cw", 32'(a_cw), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send_a(4'b1011);
    chk("t1_cw", 32'(a_cw), 32'h5A);
    lo = 0; sc = 0;
    for (int i = 0; i < 7; i++) begin
      lo += int'(!a_ready);
      sc += int'(a_sof);
      @(negedge clk);
    end
    chk("t1_ready_low", 32'(lo), 32'd7);
    chk("t1_sof_count", 32'(sc), 32'd1);
    chk("t1_ready_back", 32'(a_ready), 32'd1);
    a_sofs.delete();
    f0 = a_frames;
    a_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_rdy_a();
      a_data = v[k];
      qa.push_back(enc(v[k]));
      @(negedge clk);
      chk("b2b_cw", 32'(a_cw), 32'(x[k]));
      if (k == 2) a_valid = 1'b0;
    end
    wait_frames_a(f0 + 3);
    chk("b2b_sofs", 32'(a_sofs.size()), 32'd3);
    if (a_sofs.size() == 3) begin
      chk("b2b_period0", 32'(a_sofs[1] - a_sofs[0]), 32'd8);
      chk("b2b_period1", 32'(a_sofs[2] - a_sofs[1]), 32'd8);
    end
    f0 = a_frames;
    send_a(4'b0110);
    a_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a_data = 4'($urandom);
      @(negedge clk);
    end
    a_valid = 1'b0;
    wait_frames_a(f0 + 1);
    repeat (2) @(negedge clk);
    chk("hold_cw", 32'(a_cw), 32'h36);
    chk("hold_busy", 32'(a_busy), 32'd0);
    b_sofs.delete();
    wait_rdy_b();
    b_valid = 1'b1;
    b_data = 4'b1011;
    qb.push_back(7'h5A);
    @(negedge clk);
    chk("div3_cw", 32'(b_cw), 32'h5A);
    ec = 0; gl = 0;
    for (int i = 0; i < 23; i++) begin
      ec += int'(b_en);
      gl += int'(!b_en && !b_ready);
      @(negedge clk);
    end
    chk("div3_en_clks", 32'(ec), 32'd21);
    chk("div3_gap_clks", 32'(gl), 32'd2);
    chk("div3_ready_back", 32'(b_ready), 32'd1);
    qb.push_back(7'h5A);
    @(negedge clk);
    b_valid = 1'b0;
    for (int t = 0; t < 60 && b_frames < 2; t++) @(negedge clk);
    chk("div3_frames", 32'(b_frames), 32'd2);
    if (b_sofs.size() == 2) chk("div3_period", 32'(b_sofs[1] - b_sofs[0]), 32'd24);
    send_a(4'h9);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(a_en), 32'd0);
    chk("arst_bit", 32'(a_bit), 32'd0);
    chk("arst_cw", 32'(a_cw), 32'd0);
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_ready", 32'(a_ready), 32'd1);
    f0 = a_frames;
    send_a(4'b1000);
    wait_frames_a(f0 + 1);
    chk("arst_clean", 32'(a_last), 32'h46);
    for (int n = 0; n < 16; n++) begin
      f0 = a_frames;
      send_a(4'(n));
      wait_frames_a(f0 + 1);
      chk("loopback", 32'(correct(a_last ^ (7'h40 >> (n % 7)))), 32'(n));
    end
    repeat (2) @(negedge clk);
    chk("qa_empty", 32'(qa.size()), 32'd0);
    chk("qb_empty", 32'(qb.size()), 32'd0);
    chk("idle_bit_zero", 32'(idle_err), 32'd0);
    chk("div3_bit_hold", 32'(hold_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
